// File: rtl/multdiv_unit.sv
// ----------------------------------------------------------------------------
// multdiv_unit
//
// Iterative 32-bit signed multiply / divide unit with a fixed 33-cycle latency.
//
// A request is accepted on the rising edge E0 where the unit is idle and
// ctrl_MULT or ctrl_DIV is high. ctrl_MULT wins if both are high. The operands
// are captured at E0 and the inputs are ignored afterwards. The unit then runs
// 32 iterations (E1..E32), one bit per cycle, on the operand magnitudes. At E33
// it registers the signed result and the exception flag and pulses
// data_resultRDY for one cycle. A new request may be accepted at E34, the edge
// that ends the data_resultRDY cycle.
//
// Handshake: there is no backpressure. A request is accepted exactly when it is
// sampled high on a rising edge while busy is low. Requests sampled while busy
// is high are dropped. data_resultRDY is a one-cycle strobe that qualifies
// data_result and data_exception. Both of those hold their value until the next
// completion or reset.
//
// Ports
//   clk             in   clock; all state changes on the rising edge
//   clr             in   asynchronous active-high reset
//   data_operandA   in   32  signed multiplicand / dividend
//   data_operandB   in   32  signed multiplier / divisor
//   ctrl_MULT       in   start-multiply request
//   ctrl_DIV        in   start-divide request
//   data_result     out  32  registered result (product low word or quotient)
//   data_exception  out  registered overflow / divide-by-zero flag
//   data_resultRDY  out  one-cycle completion strobe
//   busy            out  high while an operation is in flight
//   o_dbg_state     out  2   current FSM state (0 IDLE, 1 MUL, 2 DIV)
// ----------------------------------------------------------------------------
module multdiv_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Iteration count at which the completion edge happens (after 32 iterations).
  localparam logic [5:0] LAST_COUNT = 6'd32;

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_count;

  // Operands as captured at E0, kept for the divide special cases.
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_neg;      // result sign: operand signs differ

  // Multiply working registers (shift-add on magnitudes).
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;

  // Divide working registers (restoring division on magnitudes).
  // r_quo starts as the dividend magnitude. Each step shifts a dividend bit
  // out of the top and shifts a quotient bit in at the bottom.
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;

  // Output registers.
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;

  // FSM decode strobes.
  logic        w_start_mul;
  logic        w_start_div;
  logic        w_iterate;
  logic        w_finish;

  // Datapath wires.
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_mul_acc_next;
  logic [63:0] w_product;
  logic        w_mul_ovf;
  logic [33:0] w_div_shift;
  logic [33:0] w_div_diff;
  logic        w_div_fits;
  logic [31:0] w_quotient;
  logic        w_div_by_zero;
  logic        w_div_ovf;
  logic        w_unused;

  // --------------------------------------------------------------------------
  // Operand magnitudes. 0x80000000 maps to 0x80000000, which is read as the
  // unsigned value 2^31, so no intermediate overflow occurs.
  // --------------------------------------------------------------------------
  assign w_mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign w_mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and decode strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_start_mul  = 1'b0;
    w_start_div  = 1'b0;
    w_iterate    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          w_start_mul  = 1'b1;
          w_next_state = ST_MUL;
        end else if (ctrl_DIV) begin
          w_start_div  = 1'b1;
          w_next_state = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        // Requests are ignored here. The operation runs to completion.
        if (r_count == LAST_COUNT) begin
          w_finish     = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_iterate = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Multiply step and final sign / overflow
  // --------------------------------------------------------------------------
  assign w_mul_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_product      = r_neg ? (~r_acc + 64'd1) : r_acc;
  // Signed overflow when the product does not fit in 32 bits.
  // That happens when bits 63..31 are not all equal.
  assign w_mul_ovf      = ~((&w_product[63:31]) | ~(|w_product[63:31]));

  // --------------------------------------------------------------------------
  // Divide step: shift the next dividend bit into the partial remainder, then
  // try a subtraction. A non-negative difference means the quotient bit is 1.
  // The shifted remainder can need 33 bits, so the arithmetic is 34 bits wide.
  // That leaves a sign bit for the borrow.
  // --------------------------------------------------------------------------
  assign w_div_shift = {1'b0, r_rem, r_quo[31]};
  assign w_div_diff  = w_div_shift - {2'b00, r_divisor};
  assign w_div_fits  = ~w_div_diff[33];
  // After a successful subtraction the remainder is below the divisor, so it
  // fits in 32 bits. Bit 32 of the difference is always zero.
  assign w_unused    = w_div_diff[32];

  assign w_quotient    = r_neg ? (~r_quo + 32'd1) : r_quo;
  assign w_div_by_zero = (r_op_b == 32'd0);
  assign w_div_ovf     = (r_op_a == 32'h8000_0000) && (r_op_b == 32'hFFFF_FFFF);

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count   <= 6'd0;
      r_op_a    <= 32'd0;
      r_op_b    <= 32'd0;
      r_neg     <= 1'b0;
      r_acc     <= 64'd0;
      r_mcand   <= 64'd0;
      r_mplier  <= 32'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_result  <= 32'd0;
      r_exc     <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start_mul || w_start_div) begin
        r_count   <= 6'd0;
        r_op_a    <= data_operandA;
        r_op_b    <= data_operandB;
        r_neg     <= data_operandA[31] ^ data_operandB[31];
        r_acc     <= 64'd0;
        r_mcand   <= {32'd0, w_mag_a};
        r_mplier  <= w_mag_b;
        r_rem     <= 32'd0;
        r_quo     <= w_mag_a;
        r_divisor <= w_mag_b;
      end else if (w_iterate) begin
        r_count <= r_count + 6'd1;
        if (r_state == ST_MUL) begin
          r_acc    <= w_mul_acc_next;
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
        end else begin
          r_rem <= w_div_fits ? w_div_diff[31:0] : w_div_shift[31:0];
          r_quo <= {r_quo[30:0], w_div_fits};
        end
      end else if (w_finish) begin
        r_count <= 6'd0;
        r_rdy   <= 1'b1;
        if (r_state == ST_MUL) begin
          r_result <= w_product[31:0];
          r_exc    <= w_mul_ovf;
        end else if (w_div_by_zero) begin
          r_result <= 32'd0;
          r_exc    <= 1'b1;
        end else if (w_div_ovf) begin
          r_result <= 32'h8000_0000;
          r_exc    <= 1'b1;
        end else begin
          r_result <= w_quotient;
          r_exc    <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state != ST_IDLE);
  assign o_dbg_state    = r_state;

endmodule
